exponent_unit: RTL

Pipelined, parametrised floating-point exponent datapath for the multiply/divide/square-root unit. It computes the biased result exponent for mul, div and sqrt. It then applies the normalisation decrement from the mantissa path, detects overflow and underflow, and presents the result through a valid/ready handshake. The block sits beside the mantissa pipeline and replaces the single-cycle combinational exponent logic with a two-stage elastic pipeline.

---
 rtl/exponent_unit_if.sv | 30 +++
 rtl/exponent_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/exponent_unit_if.sv
// Handshake bundle for exponent_unit: operand side (in_*) and result side (out_*).
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid && ready; the
// sender holds valid and its payload stable until then, and ready may depend combinationally on valid.
interface exponent_unit_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] e1;
    logic [WIDTH-1:0] e2;
    logic             decrement;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] e3;
    logic             shift;
    logic             overflow;
    logic             underflow;
    logic             illegal;

    modport master (
        output in_valid, op, e1, e2, decrement, out_ready,
        input  in_ready, out_valid, e3, shift, overflow, underflow, illegal
    );

    modport slave (
        input  in_valid, op, e1, e2, decrement, out_ready,
        output in_ready, out_valid, e3, shift, overflow, underflow, illegal
    );
endinterface

// File: rtl/exponent_unit.sv
// Two-stage elastic exponent datapath for mul/div/sqrt with normalisation decrement.
// Define EXP_SATURATE_EN for saturation with overflow/underflow flags; otherwise e3 wraps.
module exponent_unit #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    exponent_unit_if.slave bus
);
    localparam int XW = WIDTH + 2;
    localparam logic signed [XW-1:0] BIAS  = XW'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [XW-1:0] MAX_T = XW'((1 << WIDTH) - 1);

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_SQRT = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;

    logic                 s1_valid_q, s1_valid_d;
    logic signed [XW-1:0] r_q, r_d;
    logic                 s1_shift_q, s1_shift_d;
    logic                 s1_ill_q, s1_ill_d;

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     e3_q, e3_d;
    logic                 shift_q;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 ill_q;

    logic                 s2_free;
    logic                 accept;
    logic                 advance;

    assign s2_free      = !out_valid_q || bus.out_ready;
    assign advance      = s1_valid_q && s2_free;
    assign bus.in_ready = rst_n && (!s1_valid_q || s2_free);
    assign accept       = bus.in_valid && bus.in_ready;

    // Stage 1: raw biased exponent from zero-extended operands.
    logic signed [XW-1:0] e1_x, e2_x, u, u_even;

    always_comb begin
        e1_x       = signed'({2'b00, bus.e1});
        e2_x       = signed'({2'b00, bus.e2});
        u          = e1_x - BIAS;
        u_even     = u - signed'({{(XW-1){1'b0}}, u[0]});
        r_d        = '0;
        s1_shift_d = 1'b0;
        s1_ill_d   = 1'b0;
        case (bus.op)
            OP_DIV:  r_d = e1_x - e2_x + BIAS;
            OP_MUL:  r_d = e1_x + e2_x - BIAS;
            OP_SQRT: begin
                s1_shift_d = u[0];
                r_d        = (u_even >>> 1) + BIAS;
            end
            default: s1_ill_d = 1'b1;
        endcase
    end

    // New operands win over the departing entry when both happen in one cycle.
    always_comb begin
        s1_valid_d = s1_valid_q;
        if (accept) begin
            s1_valid_d = 1'b1;
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage 2: decrement is only looked at in the transfer cycle.
    logic signed [XW-1:0] t;

    assign t = r_q - signed'({{(XW-1){1'b0}}, bus.decrement});

`ifdef EXP_SATURATE_EN
    always_comb begin
        e3_d  = t[WIDTH-1:0];
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (t >= MAX_T) begin
            e3_d  = '1;
            ovf_d = 1'b1;
        end else if (t <= 0) begin
            e3_d  = '0;
            unf_d = 1'b1;
        end
        if (s1_ill_q) begin
            e3_d  = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end
`else
    logic unused_t_hi;
    logic unused_max;

    assign unused_t_hi = ^t[XW-1:WIDTH];
    assign unused_max  = ^MAX_T;

    always_comb begin
        e3_d  = s1_ill_q ? '0 : t[WIDTH-1:0];
        ovf_d = 1'b0;
        unf_d = 1'b0;
    end
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        if (s2_free) begin
            out_valid_d = s1_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            r_q         <= '0;
            s1_shift_q  <= 1'b0;
            s1_ill_q    <= 1'b0;
            out_valid_q <= 1'b0;
            e3_q        <= '0;
            shift_q     <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            if (accept) begin
                r_q        <= r_d;
                s1_shift_q <= s1_shift_d;
                s1_ill_q   <= s1_ill_d;
            end
            if (advance) begin
                e3_q    <= e3_d;
                shift_q <= s1_shift_q;
                ovf_q   <= ovf_d;
                unf_q   <= unf_d;
                ill_q   <= s1_ill_q;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.e3        = e3_q;
    assign bus.shift     = shift_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign bus.illegal   = ill_q;
endmodule
